// File: rtl/addsub_rr_arbiter.sv
// Four-way round-robin arbiter in front of a shared ripple adder/subtracter.
// Each operation is one capture cycle, one execute cycle and a held response.
module addsub_rr_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] a_in,
  input  logic [4*WIDTH-1:0] b_in,
  input  logic [3:0]         s_in,
  output logic [3:0]         gnt,
  output logic               rsp_valid,
  output logic [1:0]         rsp_id,
  output logic [WIDTH-1:0]   rsp_sum,
  output logic               rsp_v,
  output logic               rsp_cout,
  output logic               rsp_zero,
  input  logic               rsp_ready
);

  localparam int unsigned N_REQ = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e             state_q;
  logic [1:0]         ptr_q;
  logic [1:0]         id_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               s_q;
  logic [3:0]         gnt_q;
  logic               valid_q;
  logic [1:0]         rsp_id_q;
  logic [WIDTH-1:0]   sum_q;
  logic               v_q;
  logic               cout_q;
  logic               zero_q;

  logic [1:0]         win_id;
  logic [1:0]         cand;
  logic               win_found;
  logic [WIDTH-1:0]   bx;
  logic [WIDTH-1:0]   sum_c;
  logic [WIDTH:0]     carry;

  // First active request at or after the pointer, wrapping modulo 4.
  always_comb begin
    win_id    = ptr_q;
    win_found = 1'b0;
    cand      = ptr_q;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Ripple a + (b ^ s) + s; the carry chain also feeds the overflow flag.
  always_comb begin
    bx       = b_q ^ {WIDTH{s_q}};
    carry    = '0;
    carry[0] = s_q;
    sum_c    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_c[i]   = a_q[i] ^ bx[i] ^ carry[i];
      carry[i+1] = (a_q[i] & bx[i]) | (carry[i] & (a_q[i] ^ bx[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= 1'b0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      rsp_id_q <= '0;
      sum_q    <= '0;
      v_q      <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            id_q    <= win_id;
            a_q     <= a_in[win_id*WIDTH +: WIDTH];
            b_q     <= b_in[win_id*WIDTH +: WIDTH];
            s_q     <= s_in[win_id];
            gnt_q   <= 4'b0001 << win_id;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          gnt_q    <= '0;
          rsp_id_q <= id_q;
          sum_q    <= sum_c;
          v_q      <= carry[WIDTH-1] ^ carry[WIDTH];
          cout_q   <= carry[WIDTH];
          zero_q   <= (sum_c == '0);
          valid_q  <= 1'b1;
          state_q  <= RESP;
        end
        RESP: begin
          // The served requester drops to lowest priority once its result is taken.
          if (rsp_ready) begin
            valid_q <= 1'b0;
            ptr_q   <= id_q + 2'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = sum_q;
  assign rsp_v     = v_q;
  assign rsp_cout  = cout_q;
  assign rsp_zero  = zero_q;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter plus directed
// scenarios with literal expectations and a randomized requester phase.
module tb_addsub_rr_arbiter;

  localparam int unsigned W = 4;
  localparam int          M = 1 << W;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] a_in;
  logic [4*W-1:0] b_in;
  logic [3:0]     s_in;
  logic [3:0]     gnt;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_v;
  logic           rsp_cout;
  logic           rsp_zero;
  logic           rsp_ready;

  int n_chk  = 0;
  int n_pass = 0;
  int gq[$];

  // Model state: phase 0 waiting, 1 executing, 2 holding a response.
  int         m_ph, m_ptr, m_id;
  int         m_a, m_b;
  bit         m_s;
  logic [3:0] e_gnt;
  bit         e_val;
  int         e_id, e_sum;
  bit         e_v, e_c, e_z;

  addsub_rr_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .s_in      (s_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_v     (rsp_v),
    .rsp_cout  (rsp_cout),
    .rsp_zero  (rsp_zero),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Integer arithmetic reference: wrap modulo 2^W, signed range check for v.
  task automatic ref_op(input int ua, input int ub, input bit s,
                        output int sum, output bit v, output bit c, output bit z);
    int sa, sb, r, sr;
    sa = (ua >= M/2) ? ua - M : ua;
    sb = (ub >= M/2) ? ub - M : ub;
    if (!s) begin
      r  = ua + ub;
      c  = (r >= M);
      sr = sa + sb;
    end else begin
      r  = ua - ub + M;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    sum = r % M;
    v   = (sr > M/2 - 1) || (sr < -(M/2));
    z   = (sum == 0);
  endtask

  task automatic model_step();
    int  idx;
    bit  found;
    if (rst) begin
      m_ph = 0; m_ptr = 0; m_id = 0;
      e_gnt = '0; e_val = 0; e_id = 0; e_sum = 0; e_v = 0; e_c = 0; e_z = 0;
    end else begin
      case (m_ph)
        0: begin
          e_gnt = '0;
          found = 0;
          for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (!found && req[idx]) begin
              found = 1;
              m_id  = idx;
            end
          end
          if (found) begin
            m_a   = int'(a_in[m_id*W +: W]);
            m_b   = int'(b_in[m_id*W +: W]);
            m_s   = s_in[m_id];
            e_gnt = 4'b0001 << m_id;
            m_ph  = 1;
          end
        end
        1: begin
          e_gnt = '0;
          ref_op(m_a, m_b, m_s, e_sum, e_v, e_c, e_z);
          e_id  = m_id;
          e_val = 1;
          m_ph  = 2;
        end
        default: begin
          if (rsp_ready) begin
            e_val = 0;
            m_ptr = (m_id + 1) % 4;
            m_ph  = 0;
          end
        end
      endcase
    end
  endtask

  // Every cycle: advance the model at the edge, compare shortly after it.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("m_gnt", 32'(gnt), 32'(e_gnt));
    chk("m_valid", 32'(rsp_valid), 32'(e_val));
    if (e_val) begin
      chk("m_id", 32'(rsp_id), 32'(e_id));
      chk("m_sum", 32'(rsp_sum), 32'(e_sum));
      chk("m_v", 32'(rsp_v), 32'(e_v));
      chk("m_cout", 32'(rsp_cout), 32'(e_c));
      chk("m_zero", 32'(rsp_zero), 32'(e_z));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_ops(input int i, input int a, input int b, input bit s);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
    s_in[i]        = s;
  endtask

  task automatic do_op(input int i, input int a, input int b, input bit s,
                       input int esum, input bit ev, input bit ec, input bit ez);
    int t;
    @(negedge clk);
    rsp_ready = 1'b0;
    req = 4'b0001 << i;
    set_ops(i, a, b, s);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!gnt[i] && t < 8);
    chk("op_gnt_latency", 32'(t), 32'd1);
    @(negedge clk);
    req[i] = 1'b0;
    chk("op_valid", 32'(rsp_valid), 32'd1);
    chk("op_id", 32'(rsp_id), 32'(i));
    chk("op_sum", 32'(rsp_sum), 32'(esum));
    chk("op_v", 32'(rsp_v), 32'(ev));
    chk("op_cout", 32'(rsp_cout), 32'(ec));
    chk("op_zero", 32'(rsp_zero), 32'(ez));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("op_done", 32'(rsp_valid), 32'd0);
  endtask

  // Serve everything outstanding; requesters drop once granted.
  task automatic drain(input int n);
    bit g[4];
    for (int i = 0; i < 4; i++) g[i] = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) g[i] = 1;
        else if (g[i]) req[i] = 1'b0;
      end
    end
    req = '0;
    rsp_ready = 1'b0;
  endtask

  // Requester emulation: hold until granted, idle for a while, then re-request.
  task automatic run_auto(input int n, input bit rnd, input bit logq);
    int cnt[4];
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          if (logq) gq.push_back(i);
          cnt[i] = rnd ? int'($urandom_range(1, 4)) : 3;
        end else begin
          if (cnt[i] > 0) begin
            req[i] = 1'b0;
            cnt[i]--;
          end
          if (cnt[i] == 0 && !req[i] && (!rnd || $urandom_range(0, 2) == 0)) begin
            req[i] = 1'b1;
            set_ops(i, int'($urandom_range(0, M-1)), int'($urandom_range(0, M-1)),
                    1'($urandom));
          end
        end
      end
      rsp_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; a_in = '0; b_in = '0; s_in = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_sum", 32'(rsp_sum), 32'd0);
    chk("rst_v", 32'(rsp_v), 32'd0);
    chk("rst_cout", 32'(rsp_cout), 32'd0);
    chk("rst_zero", 32'(rsp_zero), 32'd0);

    // Basic add and the arithmetic corner cases.
    do_op(0, 3, 4, 1'b0, 7, 1'b0, 1'b0, 1'b0);
    do_op(0, 7, 1, 1'b0, 8, 1'b1, 1'b0, 1'b0);
    do_op(0, 5, 3, 1'b1, 2, 1'b0, 1'b1, 1'b0);
    do_op(0, 3, 5, 1'b1, 14, 1'b0, 1'b0, 1'b0);
    do_op(0, 8, 1, 1'b1, 7, 1'b1, 1'b1, 1'b0);
    do_op(0, 5, 5, 1'b1, 0, 1'b0, 1'b1, 1'b1);
    do_op(2, 9, 9, 1'b0, 2, 1'b1, 1'b1, 1'b0);

    // Backpressure: response held five cycles while 1 and 2 wait.
    @(negedge clk);
    rsp_ready = 1'b0;
    req = 4'b0001;
    set_ops(0, 2, 3, 1'b0);
    @(negedge clk);
    chk("bp_gnt", 32'(gnt), 32'd1);
    req = 4'b0111;
    set_ops(1, 6, 1, 1'b1);
    set_ops(2, 4, 4, 1'b0);
    @(negedge clk);
    req[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_sum", 32'(rsp_sum), 32'd5);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_no_gnt", 32'(gnt), 32'd0);
      @(negedge clk);
    end
    chk("bp_valid_last", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_idle_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("bp_next_gnt", 32'(gnt), 32'd2);
    drain(24);

    // Request raised during RESP waits until the cycle after the handshake.
    @(negedge clk);
    rsp_ready = 1'b0;
    req = 4'b0001;
    set_ops(0, 1, 1, 1'b0);
    @(negedge clk);
    chk("late_gnt0", 32'(gnt), 32'd1);
    @(negedge clk);
    req = 4'b0100;
    set_ops(2, 7, 7, 1'b1);
    chk("late_resp", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("late_resp2", 32'(rsp_valid), 32'd1);
    chk("late_no_gnt", 32'(gnt), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("late_idle_gnt", 32'(gnt), 32'd0);
    chk("late_idle_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("late_gnt2", 32'(gnt), 32'd4);
    drain(24);

    // Reset during EXEC aborts the op and returns the pointer to 0.
    do_op(1, 2, 1, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    req = 4'b0100;
    set_ops(2, 1, 2, 1'b1);
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'd4);
    rst = 1'b1;
    req = '0;
    #1;
    chk("abort_gnt_clr", 32'(gnt), 32'd0);
    chk("abort_valid_clr", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1010;
    set_ops(1, 4, 2, 1'b0);
    set_ops(3, 4, 2, 1'b1);
    @(negedge clk);
    chk("abort_ptr0_gnt", 32'(gnt), 32'd2);
    drain(24);

    // Four persistent requesters are served strictly in rotation.
    do_reset();
    gq.delete();
    run_auto(30, 1'b0, 1'b1);
    chk("rr_count_ok", 32'(gq.size() >= 8), 32'd1);
    for (int k = 0; k < 8 && k < gq.size(); k++) chk("rr_order", 32'(gq[k]), 32'(k % 4));
    drain(30);

    // Randomized traffic with random backpressure.
    run_auto(3000, 1'b1, 1'b0);
    drain(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
- Shares one WIDTH-bit binary adder/subtracter (a + (b XOR s) + s, overflow v = carry into MSB XOR carry out) among four requesters.
- Round-robin arbitration, operand capture, one execute cycle and a held response with valid/ready backpressure.
- Sits between the requesting control units and the arithmetic datapath. The add/sub function is built inside this block.

Parameters:
WIDTH, 4, operand/result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req  input  4  request per requester i; held high with operands stable until gnt[i] seen
a_in  input  4*WIDTH  operand a; requester i on bits [i*WIDTH +: WIDTH]
b_in  input  4*WIDTH  operand b; same packing as a_in
s_in  input  4  op select per requester; 0 = add, 1 = subtract (a - b)
gnt  output  4  one-hot; high for exactly one cycle when winner's operands are captured
rsp_valid  output  1  result available
rsp_id  output  2  index of requester owning the result
rsp_sum  output  WIDTH  result
rsp_v  output  1  signed (two's complement) overflow
rsp_cout  output  1  carry out of MSB; on subtract, 1 = no borrow (a >= b unsigned)
rsp_zero  output  1  rsp_sum == 0
rsp_ready  input  1  consumer accepts result when high with rsp_valid

Behaviour:
- Reset (async, rst = 1):
  - state = IDLE, rr pointer = 0.
  - gnt = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_v = 0, rsp_cout = 0, rsp_zero = 0.
  - Reset mid-operation discards captured operands and any pending response; no gnt or rsp_valid follows.
- FSM states: IDLE, EXEC, RESP.
- IDLE, clock edge with req != 0:
  - Winner = first set req bit searching ptr, ptr+1, ... modulo 4.
  - Latch winner's a, b, s and id; go to EXEC.
  - With req == 0, stay in IDLE.
- EXEC (exactly 1 cycle):
  - gnt[id] = 1; all other gnt bits 0, and gnt is 0 in every other state.
  - At the edge, register rsp_sum, rsp_v, rsp_cout, rsp_zero and rsp_id; go to RESP.
- RESP:
  - rsp_valid = 1; all rsp_* outputs stay stable until the handshake.
  - On an edge with rsp_ready = 1: ptr = (id + 1) mod 4, rsp_valid drops, go to IDLE.
  - rsp_* data holds its last value after the handshake; it is don't-care while rsp_valid = 0.
- Requester rules:
  - Requester drops req (or presents a new op) no earlier than the cycle after gnt.
  - req is not sampled in EXEC or RESP.
  - Requests arriving during EXEC/RESP wait; they are never lost while held.
- Latency:
  - req sampled at edge k → gnt high in cycle k+1 → rsp_valid high from cycle k+2.
  - Minimum 3 cycles per operation (IDLE, EXEC, RESP with ready = 1); back-to-back throughput is one op per 3 cycles.
- Arithmetic:
  - Full WIDTH-bit ripple add of a + (b XOR {WIDTH{s}}) + s.
  - Results are modulo 2^WIDTH (wrap-around); no saturation.
  - v = c[WIDTH-1] XOR c[WIDTH], where c[WIDTH] is the carry out.
- Fairness: the winner becomes lowest priority after its response completes. Four persistent requesters are each served once per 4 operations.
- Unused operand slices of non-winning requesters have no effect.

Test Plan:
1. WIDTH=4, req=0001, a0=3, b0=4, s0=0 → gnt=0001 one cycle later; rsp_valid next cycle with rsp_sum=7, v=0, cout=0, zero=0, id=0.
2. Overflow and subtract cases:
   - req0 a=7, b=1, add → sum=8, v=1, cout=0.
   - a=5, b=3, sub → sum=2, v=0, cout=1.
   - a=3, b=5, sub → sum=14, v=0, cout=0.
   - a=8, b=1, sub → sum=7, v=1, cout=1.
   - a=5, b=5, sub → sum=0, zero=1, cout=1.
3. After reset, req=1111 held (each requester drops after its gnt and re-raises 2 cycles later) → gnt order 0,1,2,3,0,... with rsp_id matching each grant.
4. rsp_ready held low 5 cycles during RESP, with req=0110 pending → rsp_valid and rsp_* stable for 5 cycles, gnt stays 0. After ready: next gnt=0010 if ptr ≤ 1, per the round-robin rule.
5. Assert rst for one cycle while in EXEC (gnt high) → gnt, rsp_valid and ptr go 0 immediately; no response for the aborted op. A fresh req=1000 is then granted first (ptr=0, only requester 3 active).
6. req=0100 raised during RESP of requester 0 → not granted until the cycle after RESP exits. Then gnt=0100 two cycles after the rsp handshake edge.
